// File: rtl/load_store_unit_pkg.sv
// Shared funct3 codes, FSM state encoding and access-size helpers for the load/store unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests are dropped and flagged).
`default_nettype none

package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Unused funct3 codes fall through to a full-word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3_size(f3))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
`default_nettype none

module load_store_unit_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  lsu_size_e   size;

  assign size = f3_size(funct3_i);

  always_comb begin
    byte_v = word_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
    half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // funct3[2] distinguishes the unsigned load variants.
  always_comb begin
    load_o = word_i;
    case (size)
      SZ_BYTE: load_o = funct3_i[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_o = funct3_i[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (size)
      SZ_BYTE: begin
        case (addr_lo_i)
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          2'd3:    merged_o[31:24] = wdata_i[7:0];
          default: merged_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory; sub-word stores use read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wword_q;
  logic [31:0]       rdata_q;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merged;
  logic              req_mis;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mis_q <= 1'b0;
    else if (accept) mis_q <= req_mis;
  end

  assign misaligned = (state_q == ST_DONE) && mis_q;
`else
  assign req_mis    = 1'b0;
  assign misaligned = 1'b0;
`endif

  load_store_unit_byte_lane u_lane (
    .word_i    (mem_read_data),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wword_q),
    .load_o    (lane_load),
    .merged_o  (lane_merged)
  );

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          stall = 1'b1;
          if (req_mis)                            state_d = ST_DONE;
          else if (!req_write)                    state_d = ST_LOAD;
          else if (f3_size(req_funct3) == SZ_WORD) state_d = ST_WRITE;
          else                                    state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        state_d  = ST_DONE;
      end
      ST_RMW_RD: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // wword_q carries the store data until RMW_RD replaces it with the merged word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      wword_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wword_q  <= req_wdata;
        rdata_q  <= 32'd0;
      end
      if (state_q == ST_LOAD)   rdata_q <= lane_load;
      if (state_q == ST_RMW_RD) wword_q <= lane_merged;
    end
  end

  assign rdata          = rdata_q;
  assign mem_address    = (state_q == ST_IDLE) ? '0 : {2'b00, addr_q[ADDR_W-1:2]};
  assign mem_write_data = (state_q == ST_WRITE) ? wword_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random loads/stores against a word-array model.
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall, done, misaligned, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int n_rd = 0, n_wr = 0, n_both = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[5:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[5:0]] <= mem_write_data;
    if (mem_read) n_rd++;
    if (mem_write) n_wr++;
    if (mem_read && mem_write) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int lane_shift(input logic [2:0] f3, input logic [31:0] a);
    if (acc_size(f3) == 1) return 8 * int'(a[1:0]);
    if (acc_size(f3) == 2) return 16 * int'(a[1]);
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = acc_size(f3);
    if (sz == 4) return w;
    v = w >> lane_shift(f3, a);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int sz;
    sz = acc_size(f3);
    if (sz == 4) return wd;
    mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << lane_shift(f3, a);
    return (w & ~mask) | ((wd << lane_shift(f3, a)) & mask);
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
    if (acc_size(f3) == 2) return a[0];
    if (acc_size(f3) == 4) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle again.
  task automatic run_op(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int idx, cyc, rd0, wr0, exp_lat, exp_rd, exp_wr;
    logic trap;
    logic [31:0] exp_r;
    idx  = int'(addr[7:2]);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ref_mis(f3, addr);
`endif
    exp_r = 32'd0;
    if (trap) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!wr) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      exp_r   = ref_load(ref_mem[idx], f3, addr);
    end else if (acc_size(f3) == 4) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      ref_mem[idx] = ref_store(ref_mem[idx], f3, addr, wd);
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 1;
      ref_mem[idx] = ref_store(ref_mem[idx], f3, addr, wd);
    end
    rd0 = n_rd; wr0 = n_wr;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1 chk({tag, ":stall_req"}, {31'd0, stall}, 32'd1);
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      chk({tag, ":stall_busy"}, {31'd0, stall}, 32'd1);
    end
    req_valid = 1'b0;
    chk({tag, ":done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, ":latency"}, cyc, exp_lat);
    chk({tag, ":stall_done"}, {31'd0, stall}, 32'd0);
    chk({tag, ":misaligned"}, {31'd0, misaligned}, {31'd0, trap});
    if (!wr) chk({tag, ":rdata"}, rdata, exp_r);
    chk({tag, ":n_read"}, n_rd - rd0, exp_rd);
    chk({tag, ":n_write"}, n_wr - wr0, exp_wr);
    chk({tag, ":mem"}, mem[idx], ref_mem[idx]);
    @(posedge clk); #1;
    chk({tag, ":done_drop"}, {31'd0, done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":ctl"}, {27'd0, stall, done, misaligned, mem_read, mem_write}, 32'd0);
    chk({tag, ":rdata"}, rdata, 32'd0);
    chk({tag, ":addr"}, mem_address, 32'd0);
    chk({tag, ":wdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic       wr;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[5] = 32'h8899_AABB; ref_mem[5] = 32'h8899_AABB;
    mem[3] = 32'h1122_3344; ref_mem[3] = 32'h1122_3344;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("LB_15",  1'b0, 3'd0, 32'h15, 32'd0);
    run_op("LBU_15", 1'b0, 3'd4, 32'h15, 32'd0);
    run_op("LH_16",  1'b0, 3'd1, 32'h16, 32'd0);
    run_op("LHU_16", 1'b0, 3'd5, 32'h16, 32'd0);
    run_op("LW_14",  1'b0, 3'd2, 32'h14, 32'd0);
    run_op("SB_0D",  1'b1, 3'd0, 32'h0D, 32'hFFFF_FF5A);
    chk("SB_0D:value", mem[3], 32'h1122_5A44);
    run_op("SW_0C",  1'b1, 3'd2, 32'h0C, 32'hCAFE_F00D);
    chk("SW_0C:value", mem[3], 32'hCAFE_F00D);
    run_op("SH_22",  1'b1, 3'd1, 32'h22, 32'h0000_BEEF);
    run_op("LW_20",  1'b0, 3'd2, 32'h20, 32'd0);
    chk("LW_20:upper", {16'd0, rdata[31:16]}, 32'h0000_BEEF);
    run_op("LW_13",  1'b0, 3'd2, 32'h13, 32'd0);
    run_op("INV_F3", 1'b0, 3'd7, 32'h14, 32'd0);

    // Reset while the read half of an SB is in progress.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h0D; req_wdata = 32'h77;
    @(posedge clk); #1;
    chk("rst_mid:rmw_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b1; req_valid = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid:mem", mem[3], ref_mem[3]);

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      if (wr) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd3; default: f3 = 3'd6;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      run_op($sformatf("rnd%0d", n), wr, f3, 32'($urandom_range(0, 255)), $urandom);
    end

    chk("never_rd_and_wr", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
